aud_adc_deserializer: RTL and testbench

//  Capture side of the codec audio link: samples the codec's serial ADC stream (BCLK/ADCLRCK/ADCDAT,
//  I2S framing), deserializes the left-channel word and writes each sample to SRAM through a

---
 rtl/aud_adc_deserializer.sv | 166 ++++++++++++++++
 tb/tb_aud_adc_deserializer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_adc_deserializer.sv
// I2S ADC capture: deserializes left-channel words from the codec and
// streams them to SRAM through a valid/ready write port.
module aud_adc_deserializer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bclk,
    input  logic              i_lrc,
    input  logic              i_adcdat,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_done
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SHIFT, S_HOLD, S_PAUSE, S_STOPW
    } state_t;

    state_t            r_state;
    logic [1:0]        r_bclk_s, r_lrc_s, r_dat_s;
    logic              r_bclk_d, r_lrc_d;
    logic [DATA_W-1:0] r_shift, r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_skip, r_wr_valid, r_overflow, r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rec_len;

    logic              w_bclk_rise, w_lrc_fall, w_lrc_rise;
    logic              w_accept, w_last, w_capturing;
    logic [DATA_W-1:0] w_word;

    assign w_bclk_rise = r_bclk_s[1] & ~r_bclk_d;
    assign w_lrc_fall  = ~r_lrc_s[1] & r_lrc_d;
    assign w_lrc_rise  = r_lrc_s[1] & ~r_lrc_d;
    assign w_accept    = r_wr_valid & i_wr_ready;
    assign w_last      = (r_addr == '1);
    assign w_word      = {r_shift[DATA_W-2:0], r_dat_s[1]};
    assign w_capturing = (r_state == S_ARM) || (r_state == S_SHIFT)
                      || (r_state == S_HOLD);

    assign o_wr_valid = r_wr_valid;
    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_rec_len  = r_rec_len;
    assign o_busy     = (r_state != S_IDLE);
    assign o_overflow = r_overflow;
    assign o_done     = r_done;

    // bclk and data share one synchroniser depth so bit alignment is kept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bclk_s <= '0;
            r_lrc_s  <= '0;
            r_dat_s  <= '0;
            r_bclk_d <= 1'b0;
            r_lrc_d  <= 1'b0;
        end else begin
            r_bclk_s <= {r_bclk_s[0], i_bclk};
            r_lrc_s  <= {r_lrc_s[0], i_lrc};
            r_dat_s  <= {r_dat_s[0], i_adcdat};
            r_bclk_d <= r_bclk_s[1];
            r_lrc_d  <= r_lrc_s[1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_skip     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= '0;
            r_rec_len  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_wr_valid <= 1'b0;
                r_rec_len  <= r_rec_len + LEN_ONE;
                if (!w_last) begin
                    r_addr <= r_addr + ADDR_ONE;
                end
            end

            if (w_accept && w_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
            end else if (i_stop) begin
                if (r_state != S_IDLE) begin
                    if (r_wr_valid && !w_accept) begin
                        r_state <= S_STOPW;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            end else if (r_state == S_STOPW) begin
                if (w_accept) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            end else if (i_pause) begin
                if (w_capturing) begin
                    r_state <= S_PAUSE;
                end
            end else if (i_start && r_state == S_IDLE) begin
                r_state    <= S_ARM;
                r_addr     <= '0;
                r_rec_len  <= '0;
                r_overflow <= 1'b0;
            end else if (i_start && r_state == S_PAUSE) begin
                r_state <= S_ARM;
            end else begin
                case (r_state)
                    S_ARM, S_HOLD: begin
                        if (w_lrc_fall) begin
                            r_state <= S_SHIFT;
                            r_cnt   <= '0;
                            r_skip  <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (w_lrc_rise) begin
                            r_state <= S_HOLD;
                        end else if (w_bclk_rise) begin
                            if (r_skip) begin
                                r_skip <= 1'b0;
                            end else begin
                                r_shift <= w_word;
                                r_cnt   <= r_cnt + CNT_ONE;
                                if (r_cnt == CNT_LAST) begin
                                    r_state <= S_HOLD;
                                    if (r_wr_valid) begin
                                        r_overflow <= 1'b1;
                                    end else begin
                                        r_data     <= w_word;
                                        r_wr_valid <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aud_adc_deserializer.sv
// Directed bench for the I2S ADC deserializer: a full-size instance and
// a 3-bit-address instance share one codec stream model.
module tb_aud_adc_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk = 1'b1;
    logic lrc = 1'b1;
    logic adcdat = 1'b0;
    logic start = 1'b0, pause = 1'b0, stop = 1'b0, ready = 1'b1;
    logic start2 = 1'b0, pause2 = 1'b0, stop2 = 1'b0, ready2 = 1'b1;

    logic        wr_valid, busy, overflow, done;
    logic [19:0] addr;
    logic [15:0] data;
    logic [20:0] rec_len;
    logic        wr_valid2, busy2, overflow2, done2;
    logic [2:0]  addr2;
    logic [15:0] data2;
    logic [3:0]  rec_len2;

    int n_vec = 0;
    int n_bad = 0;

    logic [19:0] log_addr [64];
    logic [15:0] log_data [64];
    int          log_n = 0;
    int          done_cnt = 0;
    logic [2:0]  log2_addr [64];
    logic [15:0] log2_data [64];
    int          log2_n = 0;
    int          done2_cnt = 0;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic        wr;
        logic [19:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t t1 [3];
    vec_t t4 [9];

    aud_adc_deserializer #(.DATA_W(16), .ADDR_W(20)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_lrc(lrc),
        .i_adcdat(adcdat), .i_start(start), .i_pause(pause),
        .i_stop(stop), .o_wr_valid(wr_valid), .i_wr_ready(ready),
        .o_addr(addr), .o_data(data), .o_rec_len(rec_len),
        .o_busy(busy), .o_overflow(overflow), .o_done(done)
    );

    aud_adc_deserializer #(.DATA_W(16), .ADDR_W(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_lrc(lrc),
        .i_adcdat(adcdat), .i_start(start2), .i_pause(pause2),
        .i_stop(stop2), .o_wr_valid(wr_valid2), .i_wr_ready(ready2),
        .o_addr(addr2), .o_data(data2), .o_rec_len(rec_len2),
        .o_busy(busy2), .o_overflow(overflow2), .o_done(done2)
    );

    always #5 clk = ~clk;

    // log handshakes and done pulses away from the active edge
    always @(negedge clk) begin
        if (wr_valid && ready && log_n < 64) begin
            log_addr[log_n] = addr;
            log_data[log_n] = data;
            log_n++;
        end
        if (done) done_cnt++;
        if (wr_valid2 && ready2 && log2_n < 64) begin
            log2_addr[log2_n] = addr2;
            log2_data[log2_n] = data2;
            log2_n++;
        end
        if (done2) done2_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_half(input logic l, input logic [15:0] w);
        for (int b = 0; b < 18; b++) begin
            bclk = 1'b0;
            if (b == 0) lrc = l;
            adcdat = (b >= 1 && b <= 16) ? w[16-b] : 1'b0;
            #40;
            bclk = 1'b1;
            #40;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk);
        #2;
        send_half(1'b0, l);
        send_half(1'b1, r);
    endtask

    task automatic pulse(input int which);
        @(posedge clk);
        #1;
        case (which)
            0: start = 1'b1;
            1: pause = 1'b1;
            2: stop = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        stop = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        ready = v;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 40 && done_cnt == d0; k++) @(posedge clk);
        #1;
        chk("done_pulse", done_cnt, d0 + 1);
    endtask

    initial begin
        int n0;
        int d0;
        t1[0] = '{16'h1234, 16'hFFFF, 1'b1, 20'd0, 16'h1234};
        t1[1] = '{16'hABCD, 16'hFFFF, 1'b1, 20'd1, 16'hABCD};
        t1[2] = '{16'h8001, 16'hFFFF, 1'b1, 20'd2, 16'h8001};
        for (int i = 0; i < 9; i++) begin
            t4[i] = '{16'h0100 + 16'(i * 16'h0111), 16'hFFFF, i < 8,
                      20'(i), 16'h0100 + 16'(i * 16'h0111)};
        end

        #23 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", wr_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_len", rec_len, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy2", busy2, 0);

        // 1) three frames, ready held high
        pulse(0);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 3; i++) send_frame(t1[i].left, t1[i].right);
        chk("t1_nwr", log_n, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_addr%0d", i), log_addr[i], t1[i].exp_addr);
            chk($sformatf("t1_data%0d", i), log_data[i], t1[i].exp_data);
        end
        chk("t1_len", rec_len, 3);
        chk("t1_ovf", overflow, 0);

        // 2) back-pressure drops the second word
        d0 = done_cnt;
        pulse(2);
        wait_done(d0);
        chk("t2_idle", busy, 0);
        set_ready(1'b0);
        pulse(0);
        chk("t2_len0", rec_len, 0);
        send_frame(16'h1111, 16'hFFFF);
        chk("t2_valid", wr_valid, 1);
        chk("t2_addr", addr, 0);
        chk("t2_data", data, 16'h1111);
        send_frame(16'h2222, 16'hFFFF);
        chk("t2_ovf", overflow, 1);
        chk("t2_hold_data", data, 16'h1111);
        chk("t2_hold_addr", addr, 0);
        n0 = log_n;
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_nwr", log_n, n0 + 1);
        chk("t2_wr_addr", log_addr[n0], 0);
        chk("t2_wr_data", log_data[n0], 16'h1111);
        send_frame(16'h3333, 16'hFFFF);
        chk("t2_next_addr", log_addr[n0+1], 1);
        chk("t2_next_data", log_data[n0+1], 16'h3333);
        chk("t2_len", rec_len, 2);
        chk("t2_ovf_sticky", overflow, 1);

        // 3) pause mid-word, then resume
        n0 = log_n;
        fork
            send_frame(16'hDEAD, 16'hFFFF);
            begin
                #700;
                pulse(1);
            end
        join
        chk("t3_nowr", log_n, n0);
        chk("t3_busy", busy, 1);
        chk("t3_valid", wr_valid, 0);
        pulse(0);
        send_frame(16'h5A5A, 16'hFFFF);
        chk("t3_nwr", log_n, n0 + 1);
        chk("t3_addr", log_addr[n0], 2);
        chk("t3_data", log_data[n0], 16'h5A5A);
        chk("t3_len", rec_len, 3);

        // 5) stop with a write still pending
        set_ready(1'b0);
        send_frame(16'h7777, 16'hFFFF);
        chk("t5_pend", wr_valid, 1);
        d0 = done_cnt;
        n0 = log_n;
        pulse(2);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_busy", busy, 1);
        chk("t5_valid", wr_valid, 1);
        chk("t5_nodone", done_cnt, d0);
        repeat (4) @(posedge clk);
        #1;
        ready = 1'b1;
        wait_done(d0);
        chk("t5_addr", log_addr[n0], 3);
        chk("t5_data", log_data[n0], 16'h7777);
        chk("t5_len", rec_len, 4);
        chk("t5_idle", busy, 0);
        chk("t5_valid0", wr_valid, 0);

        // 6) asynchronous reset in the middle of a word with a write pending
        set_ready(1'b0);
        pulse(0);
        send_frame(16'h1357, 16'hFFFF);
        chk("t6_pend", wr_valid, 1);
        fork
            send_frame(16'h2468, 16'hFFFF);
            begin
                #503;
                rst = 1'b1;
                #1;
                chk("t6_valid", wr_valid, 0);
                chk("t6_data", data, 0);
                chk("t6_len", rec_len, 0);
                chk("t6_busy", busy, 0);
                chk("t6_ovf", overflow, 0);
                #20;
                rst = 1'b0;
            end
        join
        set_ready(1'b1);
        n0 = log_n;
        pulse(0);
        send_frame(16'h4242, 16'hFFFF);
        chk("t6_nwr", log_n, n0 + 1);
        chk("t6_addr", log_addr[n0], 0);
        chk("t6_wdata", log_data[n0], 16'h4242);
        d0 = done_cnt;
        pulse(2);
        wait_done(d0);

        // 4) small memory fills after eight samples
        pulse(3);
        chk("t4_busy", busy2, 1);
        for (int i = 0; i < 9; i++) send_frame(t4[i].left, t4[i].right);
        chk("t4_nwr", log2_n, 8);
        for (int i = 0; i < 9; i++) begin
            if (t4[i].wr) begin
                chk($sformatf("t4_addr%0d", i), log2_addr[i],
                    t4[i].exp_addr);
                chk($sformatf("t4_data%0d", i), log2_data[i],
                    t4[i].exp_data);
            end
        end
        chk("t4_done", done2_cnt, 1);
        chk("t4_busy0", busy2, 0);
        chk("t4_len", rec_len2, 8);
        chk("t4_valid0", wr_valid2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
